// File: rtl/universal_shift_reg_pkg.sv
// Shared mode encoding for the universal shift register and its bit cells.
package universal_shift_reg_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_HOLD = 2'd0;
    localparam mode_t MODE_SHR  = 2'd1;
    localparam mode_t MODE_SHL  = 2'd2;
    localparam mode_t MODE_LOAD = 2'd3;

endpackage

// File: rtl/universal_shift_reg_shift_cell.sv
// One register bit: 4:1 mode mux feeding a falling-edge flop with sync reset.
// Latency: q updates on the falling edge that samples the inputs.
// Backpressure: none, the cell acts on every falling edge.
module shift_cell
    import universal_shift_reg_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  mode_t mode,
    input  logic  right_in,
    input  logic  left_in,
    input  logic  load_in,
    output logic  nxt,
    output logic  q
);

    // right_in is the upper neighbour (shift right), left_in the lower one (shift left)
    always_comb begin
        nxt = q;
        case (mode)
            MODE_HOLD: nxt = q;
            MODE_SHR:  nxt = right_in;
            MODE_SHL:  nxt = left_in;
            MODE_LOAD: nxt = load_in;
            default:   nxt = q;
        endcase
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            q <= 1'b0;
        end else begin
            q <= nxt;
        end
    end

endmodule

// File: rtl/universal_shift_reg.sv
// Universal shift register with pattern match flag and saturating match counter.
// Latency: q, match, match_cnt, cnt_sat all reflect an edge's inputs right after that falling edge.
// Backpressure: none; every falling edge is acted on, the counter saturates instead of wrapping.
module universal_shift_reg
    import universal_shift_reg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  mode_t            mode,
    input  logic             sr_in,
    input  logic             sl_in,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] pattern,
    input  logic             cnt_clr,
    output logic [WIDTH-1:0] q,
    output logic             so_right,
    output logic             so_left,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] q_next;
    logic             hit;
    logic [CNT_W-1:0] cnt_next;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        logic right_src;
        logic left_src;

        if (i == WIDTH - 1) begin : g_top
            assign right_src = sr_in;
        end else begin : g_mid_r
            assign right_src = q[i+1];
        end

        if (i == 0) begin : g_bot
            assign left_src = sl_in;
        end else begin : g_mid_l
            assign left_src = q[i-1];
        end

        shift_cell u_cell (
            .clk      (clk),
            .rst      (rst),
            .mode     (mode),
            .right_in (right_src),
            .left_in  (left_src),
            .load_in  (d[i]),
            .nxt      (q_next[i]),
            .q        (q[i])
        );
    end

    assign so_right = q[0];
    assign so_left  = q[WIDTH-1];

    // Only shifts can produce a match event; hold and load never do.
    assign hit = ((mode == MODE_SHR) || (mode == MODE_SHL)) && (q_next == pattern);

    always_comb begin
        cnt_next = match_cnt;
        if (cnt_clr) begin
            cnt_next = '0;
        end else if (hit && (match_cnt != CNT_MAX)) begin
            cnt_next = match_cnt + 1'b1;
        end
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            match     <= 1'b0;
            match_cnt <= '0;
            cnt_sat   <= 1'b0;
        end else begin
            match     <= hit;
            match_cnt <= cnt_next;
            cnt_sat   <= (cnt_next == CNT_MAX);
        end
    end

endmodule

// File: tb/tb_universal_shift_reg.sv
// Bench: directed vector table from the test plan, then randomized traffic against a reference model.
module tb_universal_shift_reg;
    import universal_shift_reg_pkg::*;

    logic       clk = 1'b1;
    logic       rst;
    logic [1:0] mode;
    logic       sr_in, sl_in, cnt_clr;
    logic [7:0] d, pattern;

    logic [7:0] q_a, q_b;
    logic       sor_a, sol_a, sor_b, sol_b;
    logic       match_a, match_b, sat_a, sat_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    universal_shift_reg #(.WIDTH(8), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .mode(mode), .sr_in(sr_in), .sl_in(sl_in),
        .d(d), .pattern(pattern), .cnt_clr(cnt_clr),
        .q(q_a), .so_right(sor_a), .so_left(sol_a), .match(match_a),
        .match_cnt(cnt_a), .cnt_sat(sat_a)
    );

    universal_shift_reg #(.WIDTH(8), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .mode(mode), .sr_in(sr_in), .sl_in(sl_in),
        .d(d), .pattern(pattern), .cnt_clr(cnt_clr),
        .q(q_b), .so_right(sor_b), .so_left(sol_b), .match(match_b),
        .match_cnt(cnt_b), .cnt_sat(sat_b)
    );

    typedef struct {
        logic       rst;
        logic [1:0] mode;
        logic       sr;
        logic       sl;
        logic [7:0] d;
        logic [7:0] pat;
        logic       clr;
        logic [7:0] eq;
        logic       em;
        logic [7:0] ec8;
        logic [1:0] ec2;
        logic       es2;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [1:0] m, input logic s_r, input logic s_l,
                       input logic [7:0] dd, input logic [7:0] p, input logic c,
                       input logic [7:0] eq, input logic em, input logic [7:0] ec8,
                       input logic [1:0] ec2, input logic es2);
        vec_t v;
        v.rst = r; v.mode = m; v.sr = s_r; v.sl = s_l; v.d = dd; v.pat = p; v.clr = c;
        v.eq = eq; v.em = em; v.ec8 = ec8; v.ec2 = ec2; v.es2 = es2;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic r, input logic [1:0] m, input logic s_r, input logic s_l,
                         input logic [7:0] dd, input logic [7:0] p, input logic c);
        rst = r; mode = m; sr_in = s_r; sl_in = s_l; d = dd; pattern = p; cnt_clr = c;
    endtask

    task automatic check_all(input int idx, input logic [7:0] eq, input logic em,
                             input logic [7:0] ec8, input logic [1:0] ec2,
                             input logic es8, input logic es2);
        chk("q_a", idx, q_a, eq);
        chk("q_b", idx, q_b, eq);
        chk("so_right", idx, sor_a, eq[0]);
        chk("so_left", idx, sol_a, eq[7]);
        chk("match_a", idx, match_a, em);
        chk("match_b", idx, match_b, em);
        chk("cnt8", idx, cnt_a, ec8);
        chk("cnt2", idx, cnt_b, ec2);
        chk("sat8", idx, sat_a, es8);
        chk("sat2", idx, sat_b, es2);
    endtask

    // Reference model state: plain integers and arithmetic shifts.
    int m_q, m_c8, m_c2;
    bit m_match;

    function automatic int model_next(input int cur, input int md, input int s_r, input int s_l, input int dd);
        case (md)
            1:       return (cur / 2) + s_r * 128;
            2:       return ((cur * 2) % 256) + s_l;
            3:       return dd;
            default: return cur;
        endcase
    endfunction

    initial begin
        drive(1'b1, MODE_HOLD, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

        // rst r, mode, sr, sl, d, pat, clr | q, match, cnt8, cnt2, sat2
        add(1, MODE_HOLD, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0, 0);
        add(0, MODE_HOLD, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0, 0);
        add(0, MODE_LOAD, 0, 0, 8'hA5, 8'hFF, 0, 8'hA5, 0, 0, 0, 0);
        add(0, MODE_SHR,  0, 0, 8'h00, 8'hFF, 0, 8'h52, 0, 0, 0, 0);
        add(0, MODE_SHR,  0, 0, 8'h00, 8'hFF, 0, 8'h29, 0, 0, 0, 0);
        add(0, MODE_SHR,  0, 0, 8'h00, 8'hFF, 0, 8'h14, 0, 0, 0, 0);
        add(0, MODE_SHR,  0, 0, 8'h00, 8'hFF, 0, 8'h0A, 0, 0, 0, 0);
        add(0, MODE_SHR,  0, 0, 8'h00, 8'hFF, 0, 8'h05, 0, 0, 0, 0);
        add(0, MODE_SHR,  0, 0, 8'h00, 8'hFF, 0, 8'h02, 0, 0, 0, 0);
        add(0, MODE_SHR,  0, 0, 8'h00, 8'hFF, 0, 8'h01, 0, 0, 0, 0);
        add(0, MODE_SHR,  0, 0, 8'h00, 8'hFF, 0, 8'h00, 0, 0, 0, 0);
        add(0, MODE_SHL,  0, 1, 8'h00, 8'h0B, 0, 8'h01, 0, 0, 0, 0);
        add(0, MODE_SHL,  0, 0, 8'h00, 8'h0B, 0, 8'h02, 0, 0, 0, 0);
        add(0, MODE_SHL,  0, 1, 8'h00, 8'h0B, 0, 8'h05, 0, 0, 0, 0);
        add(0, MODE_SHL,  0, 1, 8'h00, 8'h0B, 0, 8'h0B, 1, 1, 1, 0);
        add(0, MODE_HOLD, 0, 0, 8'h00, 8'h0B, 0, 8'h0B, 0, 1, 1, 0);
        add(0, MODE_LOAD, 0, 0, 8'h00, 8'h00, 1, 8'h00, 0, 0, 0, 0);
        add(0, MODE_SHL,  0, 0, 8'h00, 8'h00, 0, 8'h00, 1, 1, 1, 0);
        add(0, MODE_SHL,  0, 0, 8'h00, 8'h00, 0, 8'h00, 1, 2, 2, 0);
        add(0, MODE_SHL,  0, 0, 8'h00, 8'h00, 0, 8'h00, 1, 3, 3, 1);
        add(0, MODE_SHL,  0, 0, 8'h00, 8'h00, 0, 8'h00, 1, 4, 3, 1);
        add(0, MODE_SHL,  0, 0, 8'h00, 8'h00, 0, 8'h00, 1, 5, 3, 1);
        add(0, MODE_SHL,  0, 0, 8'h00, 8'h00, 1, 8'h00, 1, 0, 0, 0);
        // reset mid-stream with q=FF, count=2, then resume
        add(0, MODE_LOAD, 0, 0, 8'hFF, 8'h00, 0, 8'hFF, 0, 0, 0, 0);
        add(0, MODE_SHR,  1, 0, 8'h00, 8'hFF, 0, 8'hFF, 1, 1, 1, 0);
        add(0, MODE_SHR,  1, 0, 8'h00, 8'hFF, 0, 8'hFF, 1, 2, 2, 0);
        add(1, MODE_SHR,  1, 0, 8'h00, 8'hFF, 0, 8'h00, 0, 0, 0, 0);
        add(0, MODE_SHR,  1, 0, 8'h00, 8'h80, 0, 8'h80, 1, 1, 1, 0);

        @(posedge clk);
        #1;
        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].mode, tbl[i].sr, tbl[i].sl, tbl[i].d, tbl[i].pat, tbl[i].clr);
            @(negedge clk);
            #1;
            check_all(i, tbl[i].eq, tbl[i].em, tbl[i].ec8, tbl[i].ec2, 1'b0, tbl[i].es2);
        end

        // Rising edge with a load request must not disturb anything.
        drive(1'b0, MODE_LOAD, 1'b0, 1'b0, 8'h3C, 8'h00, 1'b0);
        @(posedge clk);
        #1;
        chk("rise_q", 0, q_a, 8'h80);
        chk("rise_cnt", 0, cnt_a, 8'd1);

        // Randomized phase, starting from a reset.
        drive(1'b1, MODE_HOLD, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        @(negedge clk);
        #1;
        m_q = 0; m_c8 = 0; m_c2 = 0; m_match = 0;
        check_all(1000, 8'h00, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0);

        for (int s = 0; s < 600; s++) begin
            int md, sr_v, sl_v, d_v, p_v, nq;
            bit r_v, c_v, hit;
            md   = $urandom_range(0, 3);
            sr_v = $urandom_range(0, 1);
            sl_v = $urandom_range(0, 1);
            d_v  = $urandom_range(0, 255);
            r_v  = ($urandom_range(0, 59) == 0);
            c_v  = ($urandom_range(0, 19) == 0);
            nq   = model_next(m_q, md, sr_v, sl_v, d_v);
            // Bias the pattern towards the upcoming contents so matches are frequent.
            p_v  = ($urandom_range(0, 2) != 0) ? nq : $urandom_range(0, 255);
            drive(r_v, 2'(md), 1'(sr_v), 1'(sl_v), 8'(d_v), 8'(p_v), c_v);
            @(negedge clk);
            #1;
            if (r_v) begin
                m_q = 0; m_match = 0; m_c8 = 0; m_c2 = 0;
            end else begin
                hit = (md == 1 || md == 2) && (nq == p_v);
                m_match = hit;
                m_q = nq;
                if (c_v) begin
                    m_c8 = 0; m_c2 = 0;
                end else if (hit) begin
                    if (m_c8 < 255) m_c8++;
                    if (m_c2 < 3) m_c2++;
                end
            end
            check_all(2000 + s, 8'(m_q), m_match, 8'(m_c8), 2'(m_c2), m_c8 == 255, m_c2 == 3);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
